// File: rtl/game_status_uart_tx.sv
// Return-path UART transmitter: snapshots game status on request and sends a
// 5-byte 8N1 packet (header, letter, counts/flags, index mask, XOR checksum).
module game_status_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 1042,
    parameter logic [7:0]  HEADER       = 8'hA5
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       send,
    input  logic [7:0] letter,
    input  logic [2:0] correct,
    input  logic [2:0] incorrect,
    input  logic [4:0] index_correct,
    input  logic       mistake,
    input  logic       game_end,
    output logic       tx_serial,
    output logic       busy,
    output logic       done,
    output logic       overrun
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [2:0]       byte_idx_q, byte_idx_d;
    logic [7:0]       b1_q, b1_d;
    logic [7:0]       b2_q, b2_d;
    logic [7:0]       b3_q, b3_d;
    logic [7:0]       b4_q, b4_d;
    logic             tx_serial_q, tx_serial_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             overrun_q, overrun_d;

    logic             baud_last;
    logic [7:0]       cur_byte;
    logic [7:0]       snap_b2;
    logic [7:0]       snap_b3;

    assign tx_serial = tx_serial_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign overrun   = overrun_q;

    // Next-state, counter and snapshot logic
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        b1_d       = b1_q;
        b2_d       = b2_q;
        b3_d       = b3_q;
        b4_d       = b4_q;
        done_d     = 1'b0;
        overrun_d  = 1'b0;

        baud_last = (baud_cnt_q == CNT_MAX);
        snap_b2   = {correct, incorrect, mistake, game_end};
        snap_b3   = {3'b000, index_correct};

        case (state_q)
            IDLE: begin
                if (send) begin
                    state_d    = START;
                    baud_cnt_d = '0;
                    bit_idx_d  = 3'd0;
                    byte_idx_d = 3'd0;
                    b1_d       = letter;
                    b2_d       = snap_b2;
                    b3_d       = snap_b3;
                    b4_d       = HEADER ^ letter ^ snap_b2 ^ snap_b3;
                end
            end
            START: begin
                if (baud_last) begin
                    baud_cnt_d = '0;
                    bit_idx_d  = 3'd0;
                    state_d    = DATA;
                end else begin
                    baud_cnt_d = baud_cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_cnt_d = '0;
                    if (byte_idx_q == 3'd4) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        byte_idx_d = byte_idx_q + 3'd1;
                        state_d    = START;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        overrun_d = send && (state_q != IDLE);

        // Line level is derived from the next state so it lands with the state change
        case (byte_idx_d)
            3'd0:    cur_byte = HEADER;
            3'd1:    cur_byte = b1_q;
            3'd2:    cur_byte = b2_q;
            3'd3:    cur_byte = b3_q;
            default: cur_byte = b4_q;
        endcase

        case (state_d)
            START:   tx_serial_d = 1'b0;
            DATA:    tx_serial_d = cur_byte[bit_idx_d];
            default: tx_serial_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!nRst) begin
            state_q     <= IDLE;
            baud_cnt_q  <= '0;
            bit_idx_q   <= 3'd0;
            byte_idx_q  <= 3'd0;
            b1_q        <= 8'd0;
            b2_q        <= 8'd0;
            b3_q        <= 8'd0;
            b4_q        <= 8'd0;
            tx_serial_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            baud_cnt_q  <= baud_cnt_d;
            bit_idx_q   <= bit_idx_d;
            byte_idx_q  <= byte_idx_d;
            b1_q        <= b1_d;
            b2_q        <= b2_d;
            b3_q        <= b3_d;
            b4_q        <= b4_d;
            tx_serial_q <= tx_serial_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            overrun_q   <= overrun_d;
        end
    end

endmodule

// File: tb/tb_game_status_uart_tx.sv
// Bench for game_status_uart_tx: a UART decoder on tx_serial pops expected
// bytes from a scoreboard queue filled when each packet is requested.
module tb_game_status_uart_tx;

    localparam int unsigned CPB = 4;

    logic       clk = 1'b0;
    logic       nRst;
    logic       send;
    logic [7:0] letter;
    logic [2:0] correct;
    logic [2:0] incorrect;
    logic [4:0] index_correct;
    logic       mistake;
    logic       game_end;
    logic       tx_serial;
    logic       busy;
    logic       done;
    logic       overrun;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;
    logic [7:0] exp_q[$];

    game_status_uart_tx #(.CLKS_PER_BIT(CPB), .HEADER(8'hA5)) dut (
        .clk(clk), .nRst(nRst), .send(send), .letter(letter),
        .correct(correct), .incorrect(incorrect), .index_correct(index_correct),
        .mistake(mistake), .game_end(game_end), .tx_serial(tx_serial),
        .busy(busy), .done(done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_pkt(input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] b3, input logic [7:0] b4);
        exp_q.push_back(8'hA5);
        exp_q.push_back(b1);
        exp_q.push_back(b2);
        exp_q.push_back(b3);
        exp_q.push_back(b4);
    endtask

    task automatic set_nominal();
        letter = 8'h41; correct = 3'd3; incorrect = 3'd1;
        index_correct = 5'b10110; mistake = 1'b0; game_end = 1'b0;
    endtask

    task automatic set_alt();
        letter = 8'h5A; correct = 3'd5; incorrect = 3'd2;
        index_correct = 5'b01011; mistake = 1'b1; game_end = 1'b1;
    endtask

    // Leaves the bench at the first negedge of the start bit
    task automatic pulse_send();
        send = 1'b1;
        cyc(1);
        send = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!done && cycles < 400) begin
            cyc(1);
            cycles++;
        end
        if (!done) check("done_timeout", 32'(cycles), 32'd200);
    endtask

    // Monitor: decodes 8N1 frames sampled mid-bit and scores against exp_q
    initial begin
        int rx_cnt;
        bit rx_act;
        logic [7:0] rx_byte;
        rx_cnt = 0;
        rx_act = 1'b0;
        rx_byte = 8'h00;
        forever begin
            @(negedge clk);
            if (done) done_cnt++;
            if (!nRst) begin
                rx_act = 1'b0;
            end else if (!rx_act) begin
                if (tx_serial == 1'b0) begin
                    rx_act = 1'b1;
                    rx_cnt = 0;
                end
            end else begin
                rx_cnt++;
            end
            if (rx_act && nRst && (rx_cnt % CPB) == CPB / 2) begin
                int k;
                k = rx_cnt / CPB;
                if (k == 0) begin
                    check("rx_start_bit", 32'(tx_serial), 32'd0);
                end else if (k <= 8) begin
                    rx_byte[k-1] = tx_serial;
                end else begin
                    check("rx_stop_bit", 32'(tx_serial), 32'd1);
                    if (exp_q.size() == 0) begin
                        check("rx_unexpected_byte", 32'(rx_byte), 32'hFFFF_FFFF);
                    end else begin
                        check("rx_byte", 32'(rx_byte), 32'(exp_q.pop_front()));
                    end
                    rx_act = 1'b0;
                end
            end
        end
    end

    initial begin
        int cycles;
        int dsave;
        nRst = 1'b0;
        send = 1'b0;
        set_nominal();

        // 1. Reset
        cyc(5);
        check("rst_tx", 32'(tx_serial), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        nRst = 1'b1;
        cyc(3);

        // 2. Nominal packet
        push_pkt(8'h41, 8'h64, 8'h16, 8'h96);
        pulse_send();
        check("latency_tx", 32'(tx_serial), 32'd0);
        check("latency_busy", 32'(busy), 32'd1);
        wait_done(cycles);
        check("pkt_len", 32'(cycles), 32'd200);
        check("done_busy_low", 32'(busy), 32'd0);
        cyc(1);
        check("done_one_cycle", 32'(done), 32'd0);
        cyc(10);
        check("nom_queue_empty", 32'(exp_q.size()), 32'd0);
        check("nom_done_cnt", 32'(done_cnt), 32'd1);

        // 3. Snapshot isolation
        push_pkt(8'h41, 8'h64, 8'h16, 8'h96);
        pulse_send();
        letter = 8'h5A;
        wait_done(cycles);
        cyc(10);
        set_nominal();
        check("snap_queue_empty", 32'(exp_q.size()), 32'd0);

        // 4. Busy collision
        dsave = done_cnt;
        push_pkt(8'h41, 8'h64, 8'h16, 8'h96);
        pulse_send();
        cyc(60);
        send = 1'b1;
        cyc(1);
        send = 1'b0;
        check("overrun_pulse", 32'(overrun), 32'd1);
        cyc(1);
        check("overrun_clear", 32'(overrun), 32'd0);
        wait_done(cycles);
        cyc(250);
        check("collide_done_cnt", 32'(done_cnt - dsave), 32'd1);
        check("collide_idle", 32'(busy), 32'd0);
        check("collide_queue_empty", 32'(exp_q.size()), 32'd0);

        // 5. Reset during byte 2, then a fresh packet
        push_pkt(8'h41, 8'h64, 8'h16, 8'h96);
        pulse_send();
        cyc(91);
        nRst = 1'b0;
        cyc(1);
        check("midrst_tx", 32'(tx_serial), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        cyc(2);
        exp_q.delete();
        dsave = done_cnt;
        nRst = 1'b1;
        cyc(5);
        check("midrst_no_done", 32'(done_cnt - dsave), 32'd0);
        set_alt();
        push_pkt(8'h5A, 8'hAB, 8'h0B, 8'h5F);
        pulse_send();
        wait_done(cycles);
        check("fresh_pkt_len", 32'(cycles), 32'd200);
        cyc(10);
        check("fresh_queue_empty", 32'(exp_q.size()), 32'd0);

        // 6. Back-to-back: send asserted in the done cycle
        push_pkt(8'h5A, 8'hAB, 8'h0B, 8'h5F);
        push_pkt(8'h41, 8'h64, 8'h16, 8'h96);
        pulse_send();
        wait_done(cycles);
        set_nominal();
        send = 1'b1;
        cyc(1);
        send = 1'b0;
        check("b2b_start_tx", 32'(tx_serial), 32'd0);
        check("b2b_start_busy", 32'(busy), 32'd1);
        wait_done(cycles);
        check("b2b_pkt_len", 32'(cycles), 32'd200);
        cyc(10);
        check("b2b_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
